// File: rtl/cpu_defs.sv
// Shared decode/writeback constants for the register file and its read ports.
package cpu_defs;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREAD_DEF  = 2;

    // Architectural zero register index; reads of it are always 0 and never busy.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port with write-to-read bypass and busy gating.
module rf_read_port
    import cpu_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] stored,
    input  logic              busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);

    logic hit0;
    logic hit1;

    // Lane 1 is the younger retire lane, so it outranks lane 0 in the bypass.
    always_comb begin
        hit0  = we0 && (waddr0 == raddr);
        hit1  = we1 && (waddr1 == raddr);
        rdata = stored;
        rbusy = busy && !(hit0 || hit1);
        if (raddr == ADDR_W'(REG_ZERO)) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (hit1) begin
            rdata = wdata1;
        end else if (hit0) begin
            rdata = wdata0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file with bypass and a per-register busy scoreboard.
module regfile_mp_sb
    import cpu_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    sb_set,
    input  logic [ADDR_W-1:0]       sb_addr,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              byp_we0;
    logic              byp_we1;

    // Bypass is suppressed during reset so reads stay 0 while rst is held.
    assign byp_we0 = we0 && !rst;
    assign byp_we1 = we1 && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (we1 && (waddr1 == ADDR_W'(r))) regs[r] <= wdata1;
                else if (we0 && (waddr0 == ADDR_W'(r))) regs[r] <= wdata0;
            end
        end
    end

    // A same-cycle set outranks a retiring write so a newly issued producer is not lost.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        busy_nxt[REG_ZERO] = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            if (sb_set && (sb_addr == ADDR_W'(r))) busy_nxt[r] = 1'b1;
            else if ((we0 && (waddr0 == ADDR_W'(r))) || (we1 && (waddr1 == ADDR_W'(r))))
                busy_nxt[r] = 1'b0;
        end
        for (int r = 0; r < DEPTH; r++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[r]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_port (
            .raddr (ra),
            .stored(regs[ra]),
            .busy  (busy[ra]),
            .we0   (byp_we0),
            .waddr0(waddr0),
            .wdata0(wdata0),
            .we1   (byp_we1),
            .waddr1(waddr1),
            .wdata1(wdata1),
            .rdata (rdata[k*DATA_W +: DATA_W]),
            .rbusy (rbusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed-vector bench for regfile_mp_sb with four read ports.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic             clk;
    logic             rst;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             we0;
    logic [AW-1:0]    waddr0;
    logic [DW-1:0]    wdata0;
    logic             we1;
    logic [AW-1:0]    waddr1;
    logic [DW-1:0]    wdata1;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic [AW:0]      busy_cnt;

    int checks;
    int errors;

    typedef struct packed {
        logic             we0;
        logic [AW-1:0]    waddr0;
        logic [DW-1:0]    wdata0;
        logic             we1;
        logic [AW-1:0]    waddr1;
        logic [DW-1:0]    wdata1;
        logic             sb_set;
        logic [AW-1:0]    sb_addr;
        logic [NR*AW-1:0] raddr;
        logic [NR*DW-1:0] exp_rdata;
        logic [NR-1:0]    exp_rbusy;
        logic [AW:0]      exp_cnt;
    } vec_t;

    vec_t vecs [15];

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                   logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                   logic s, logic [AW-1:0] sa, logic [NR*AW-1:0] ra,
                                   logic [NR*DW-1:0] ed, logic [NR-1:0] eb, logic [AW:0] ec);
        vec_t v;
        v.we0 = w0; v.waddr0 = a0; v.wdata0 = d0;
        v.we1 = w1; v.waddr1 = a1; v.wdata1 = d1;
        v.sb_set = s; v.sb_addr = sa; v.raddr = ra;
        v.exp_rdata = ed; v.exp_rbusy = eb; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        we0 = v.we0; waddr0 = v.waddr0; wdata0 = v.wdata0;
        we1 = v.we1; waddr1 = v.waddr1; wdata1 = v.wdata1;
        sb_set = v.sb_set; sb_addr = v.sb_addr; raddr = v.raddr;
    endtask

    task automatic checkOutput(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        sb_set = 0; sb_addr = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        raddr = '0;
        rst = 1'b1;

        // Ports ordered {p3, p2, p1, p0}; each vector's outputs reflect earlier edges only.
        vecs[0]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd0},
                         {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 6'd0);
        vecs[1]  = mkVec(1, 3, 32'h11, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd3},
                         {32'h0, 32'h0, 32'h0, 32'h11}, 4'b0000, 6'd0);
        vecs[2]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd3},
                         {32'h0, 32'h0, 32'h0, 32'h11}, 4'b0000, 6'd0);
        vecs[3]  = mkVec(1, 9, 32'hAAAA, 1, 9, 32'h5555, 0, 0, {5'd0, 5'd0, 5'd3, 5'd9},
                         {32'h0, 32'h0, 32'h11, 32'h5555}, 4'b0000, 6'd0);
        vecs[4]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd9},
                         {32'h0, 32'h0, 32'h0, 32'h5555}, 4'b0000, 6'd0);
        vecs[5]  = mkVec(0, 0, 0, 0, 0, 0, 1, 4, {5'd0, 5'd0, 5'd0, 5'd4},
                         {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 6'd0);
        vecs[6]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd4, 5'd4},
                         {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0011, 6'd1);
        vecs[7]  = mkVec(0, 0, 0, 1, 4, 32'h42, 0, 0, {5'd0, 5'd0, 5'd4, 5'd4},
                         {32'h0, 32'h0, 32'h42, 32'h42}, 4'b0000, 6'd1);
        vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd4},
                         {32'h0, 32'h0, 32'h0, 32'h42}, 4'b0000, 6'd0);
        vecs[9]  = mkVec(1, 6, 32'h66, 0, 0, 0, 1, 6, {5'd0, 5'd0, 5'd0, 5'd6},
                         {32'h0, 32'h0, 32'h0, 32'h66}, 4'b0000, 6'd0);
        vecs[10] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd6},
                         {32'h0, 32'h0, 32'h0, 32'h66}, 4'b0001, 6'd1);
        vecs[11] = mkVec(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, {5'd0, 5'd0, 5'd0, 5'd0},
                         {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0000, 6'd1);
        vecs[12] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd6, 5'd0, 5'd0, 5'd0},
                         {32'h66, 32'h0, 32'h0, 32'h0}, 4'b1000, 6'd1);
        vecs[13] = mkVec(1, 8, 32'h88, 1, 7, 32'h77, 1, 7, {5'd9, 5'd6, 5'd8, 5'd7},
                         {32'h5555, 32'h66, 32'h88, 32'h77}, 4'b0100, 6'd1);
        vecs[14] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd6, 5'd8, 5'd7},
                         {32'h0, 32'h66, 32'h88, 32'h77}, 4'b0101, 6'd2);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_rdata", rdata, '0);
        checkOutput("reset_rbusy", {124'd0, rbusy}, '0);
        checkOutput("reset_cnt", {122'd0, busy_cnt}, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("v%0d_rbusy", i), {124'd0, rbusy}, {124'd0, vecs[i].exp_rbusy});
            checkOutput($sformatf("v%0d_cnt", i), {122'd0, busy_cnt}, {122'd0, vecs[i].exp_cnt});
        end

        // Reset asserted between edges must clear reads and the counter immediately.
        @(negedge clk);
        idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        sb_set = 1; sb_addr = 7;
        raddr = {5'd0, 5'd0, 5'd0, 5'd5};
        @(negedge clk);
        idle();
        #1;
        checkOutput("pre_rst_r5", {96'd0, rdata[31:0]}, {96'd0, 32'hDEADBEEF});
        checkOutput("pre_rst_cnt", {122'd0, busy_cnt}, {122'd0, 6'd2});
        @(posedge clk);
        #2;
        rst = 1'b1;
        we0 = 1; waddr0 = 5; wdata0 = 32'h12345678;
        raddr = {5'd6, 5'd7, 5'd9, 5'd5};
        #1;
        checkOutput("mid_rst_rdata", rdata, '0);
        checkOutput("mid_rst_rbusy", {124'd0, rbusy}, '0);
        checkOutput("mid_rst_cnt", {122'd0, busy_cnt}, '0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_rdata", rdata, '0);
        checkOutput("post_rst_rbusy", {124'd0, rbusy}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, two-read register file in the decode stage.
- Provides NREAD combinational read ports and two write ports.
- Write-to-read bypass: a register read in the cycle it is written returns the new value.
- Per-register busy-bit scoreboard lets decode detect RAW hazards against in-flight producers.
- Sits between decode (reads, scoreboard set) and writeback (two retire lanes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NREAD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
raddr  in  NREAD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rdata  out  NREAD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rbusy  out  NREAD  port k source has an outstanding producer (stall)
we0  in  1  write enable, lane 0
waddr0  in  ADDR_W  write address, lane 0
wdata0  in  DATA_W  write data, lane 0
we1  in  1  write enable, lane 1 (younger; wins on conflict)
waddr1  in  ADDR_W  write address, lane 1
wdata1  in  DATA_W  write data, lane 1
sb_set  in  1  mark sb_addr busy (instruction issued with destination)
sb_addr  in  ADDR_W  destination being marked
busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (async, on rst high): all registers = 0, all busy bits = 0, busy_cnt = 0. While rst is high, rdata = 0 and rbusy = 0 for every port.
- Register 0 is hardwired:
  - writes to it are dropped;
  - sb_set to it is ignored;
  - reads return 0 with rbusy = 0.
- Writes commit on the rising clk edge. Write lane collision (we0 & we1 & waddr0 == waddr1, nonzero): lane 1 data is stored.
- Read ports are combinational, 0 latency. Per-port priority:
  1. raddr == 0 -> 0;
  2. we1 and waddr1 match -> wdata1;
  3. we0 and waddr0 match -> wdata0;
  4. otherwise stored value.
- Scoreboard update per register r, next-state busy[r]:
  - if sb_set & sb_addr == r & r != 0 -> 1 (a set beats a same-cycle clear);
  - else if (we0 & waddr0 == r) | (we1 & waddr1 == r) -> 0;
  - else hold.
- Setting an already-busy register keeps it busy. The first write clears it; a single outstanding producer per destination is enforced by the issue logic, not here.
- rbusy[k] = busy[raddr_k] & ~(write this cycle to raddr_k). A same-cycle sb_set does not raise rbusy until the next cycle.
- busy_cnt is a registered popcount of busy[], updated every edge from next-state busy. Range 0..2**ADDR_W - 1; no wrap is possible.
- No other internal state and no FSM: the scoreboard bits and counter are the sequential state.

Decomposition:
- Shared package (cpu_defs): DATA_W, ADDR_W defaults and the REG_ZERO constant.
- One natural sub-module: rf_read_port (one bypass mux plus busy gating), instantiated NREAD times in a generate loop.
- Storage, scoreboard and counter stay in the top module.

Test Plan:
- Reset mid-run:
  - write r5 = 0xDEADBEEF, sb_set r7;
  - assert rst between edges -> rdata for r5 = 0 and busy_cnt = 0 immediately, before the next edge.
- Bypass:
  - we0 with waddr0 = 3, wdata0 = 0x11 and raddr0 = 3 in the same cycle -> rdata0 = 0x11 combinationally;
  - next cycle, with no write, rdata0 = 0x11.
- Lane conflict: we0 and we1 both to r9 (0xAAAA, 0x5555) -> r9 reads 0x5555 afterwards and r9 is not busy.
- Scoreboard:
  - sb_set r4 -> next cycle rbusy for r4 = 1 and busy_cnt = 1;
  - we1 r4 = 0x42 -> rbusy = 0 in that cycle with rdata = 0x42, busy_cnt = 0 next cycle.
- Set/clear collision: sb_set r6 and we0 r6 in the same cycle -> r6 busy next cycle, data = written value, busy_cnt incremented.
- Zero register:
  - we0 r0 = 0xFFFF and sb_set r0 -> raddr r0 reads 0 with rbusy = 0;
  - busy_cnt unchanged;
  - all NREAD ports checked with NREAD = 4.
